// File: rtl/mv_wback.sv
// rtl/mv_wback.sv - result write-back stage between the matrix-vector FMA lanes and the write master
//
// Purpose:
//   Buffers packed FMA result words in a show-ahead FIFO, zero-masks the
//   unused lanes of the last word of a job, and sequences one write-master
//   transfer per job (base/length, go, data stream, wait for done), then
//   pulses flag_over back to the config block.
//
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   param_ena/oaddr/olen         job start strobe, output byte base, result count
//   res_wreq/res_data            one-cycle result word strobe and packed lanes
//   wmst_ctrl_*                  write-master control (base, length, go, done)
//   wmst_user_*                  write-master data push, data word, backpressure
//   flag_over                    one-cycle job-complete pulse
//   busy                         high while a job is in progress
//   err_drop                     sticky flag: a result word was discarded
module mv_wback #(
  parameter int CW  = 10,
  parameter int VW  = 4,
  parameter int LDW = 32,
  parameter int XAW = 32,
  parameter int XDW = 128,
  parameter int FAW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           param_ena,
  input  logic [XAW-1:0] param_oaddr,
  input  logic [CW-1:0]  param_olen,
  input  logic           res_wreq,
  input  logic [XDW-1:0] res_data,
  output logic           wmst_ctrl_fixed_location,
  output logic [XAW-1:0] wmst_ctrl_write_base,
  output logic [XAW-1:0] wmst_ctrl_write_length,
  output logic           wmst_ctrl_go,
  input  logic           wmst_ctrl_done,
  output logic           wmst_user_write_buffer,
  output logic [XDW-1:0] wmst_user_write_input_data,
  input  logic           wmst_user_buffer_full,
  output logic           flag_over,
  output logic           busy,
  output logic           err_drop
);

  localparam int DEPTH = 1 << FAW;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_GO        = 2'd1,
    S_STREAM    = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [XAW-1:0] base_q, base_d;
  logic [XAW-1:0] len_q, len_d;
  logic [CW-1:0]  nwords_q, nwords_d;
  logic [CW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  sent_q, sent_d;
  logic [CW-1:0]  recv_q, recv_d;
  logic           done_seen_q, done_seen_d;
  logic           go_q, go_d;
  logic           flag_q, flag_d;
  logic           err_q, err_d;

  // FIFO storage and pointers
  logic [XDW-1:0] mem_q [DEPTH];
  logic [FAW-1:0] wptr_q, wptr_d;
  logic [FAW-1:0] rptr_q, rptr_d;
  logic [FAW:0]   cnt_q, cnt_d;

  logic           fifo_empty;
  logic           fifo_full;
  logic           pop;
  logic           push;
  logic           drop;
  logic [XDW-1:0] wdata;

  // Job geometry derived from the incoming parameters
  logic [CW:0]    olen_ext;
  logic [CW-1:0]  job_nwords;
  logic [CW-1:0]  job_tail;
  logic [XAW-1:0] job_len;

  assign olen_ext   = {1'b0, param_olen};
  assign job_nwords = CW'((olen_ext + (CW+1)'(VW - 1)) / (CW+1)'(VW));
  assign job_tail   = CW'(olen_ext % (CW+1)'(VW));
  assign job_len    = XAW'(job_nwords) * XAW'(XDW / 8);

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == (FAW+1)'(DEPTH));

  // Pop decision uses only registered FIFO state plus the backpressure input
  assign pop  = (state_q == S_STREAM) && !fifo_empty && !wmst_user_buffer_full;

  // A full FIFO still takes a word when the head leaves in the same cycle
  assign push = res_wreq && (state_q != S_IDLE) && (recv_q < nwords_q) &&
                (!fifo_full || pop);
  assign drop = res_wreq && !push;

  // Zero the lanes beyond the tail on the final word of the job
  always_comb begin
    wdata = res_data;
    if ((recv_q == nwords_q - CW'(1)) && (tail_q != '0)) begin
      for (int g = 0; g < VW; g++) begin
        if (CW'(g) >= tail_q) begin
          wdata[g*LDW +: LDW] = '0;
        end
      end
    end
  end

  // FIFO pointer/count next state
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      wptr_d = wptr_q + FAW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + FAW'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + (FAW+1)'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - (FAW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  // Control FSM next state
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    nwords_d    = nwords_q;
    tail_d      = tail_q;
    sent_d      = pop  ? sent_q + CW'(1) : sent_q;
    recv_d      = push ? recv_q + CW'(1) : recv_q;
    done_seen_d = done_seen_q;
    go_d        = 1'b0;
    flag_d      = 1'b0;
    err_d       = err_q | drop;

    unique case (state_q)
      S_IDLE: begin
        if (param_ena) begin
          if (param_olen != '0) begin
            state_d     = S_GO;
            base_d      = param_oaddr;
            len_d       = job_len;
            nwords_d    = job_nwords;
            tail_d      = job_tail;
            sent_d      = '0;
            recv_d      = '0;
            done_seen_d = 1'b0;
            go_d        = 1'b1;
            // A word dropped in this same cycle still gets reported
            err_d       = drop;
          end else begin
            flag_d = 1'b1;
          end
        end
      end
      S_GO: begin
        state_d = S_STREAM;
        if (wmst_ctrl_done) begin
          done_seen_d = 1'b1;
        end
      end
      S_STREAM: begin
        if (wmst_ctrl_done) begin
          done_seen_d = 1'b1;
        end
        if (pop && (sent_q == nwords_q - CW'(1))) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (wmst_ctrl_done || done_seen_q) begin
          state_d     = S_IDLE;
          flag_d      = 1'b1;
          done_seen_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      nwords_q    <= '0;
      tail_q      <= '0;
      sent_q      <= '0;
      recv_q      <= '0;
      done_seen_q <= 1'b0;
      go_q        <= 1'b0;
      flag_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      nwords_q    <= nwords_d;
      tail_q      <= tail_d;
      sent_q      <= sent_d;
      recv_q      <= recv_d;
      done_seen_q <= done_seen_d;
      go_q        <= go_d;
      flag_q      <= flag_d;
      err_q       <= err_d;
    end
  end

  assign wmst_ctrl_fixed_location   = 1'b0;
  assign wmst_ctrl_write_base       = base_q;
  assign wmst_ctrl_write_length     = len_q;
  assign wmst_ctrl_go               = go_q;
  assign wmst_user_write_buffer     = pop;
  // Stale memory contents are hidden while the FIFO is empty
  assign wmst_user_write_input_data = fifo_empty ? '0 : mem_q[rptr_q];
  assign flag_over                  = flag_q;
  assign busy                       = (state_q != S_IDLE);
  assign err_drop                   = err_q;

endmodule

// File: tb/tb_mv_wback.sv
// tb/tb_mv_wback.sv - self-checking scoreboard bench for mv_wback
module tb_mv_wback;

  logic         clk = 1'b0;
  logic         rst;
  logic         param_ena;
  logic [31:0]  param_oaddr;
  logic [9:0]   param_olen;
  logic         res_wreq;
  logic [127:0] res_data;
  logic         wmst_ctrl_fixed_location;
  logic [31:0]  wmst_ctrl_write_base;
  logic [31:0]  wmst_ctrl_write_length;
  logic         wmst_ctrl_go;
  logic         wmst_ctrl_done;
  logic         wmst_user_write_buffer;
  logic [127:0] wmst_user_write_input_data;
  logic         wmst_user_buffer_full;
  logic         flag_over;
  logic         busy;
  logic         err_drop;

  int checks = 0;
  int errors = 0;
  int n_push = 0;
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;

  mv_wback dut (
    .clk                        (clk),
    .rst                        (rst),
    .param_ena                  (param_ena),
    .param_oaddr                (param_oaddr),
    .param_olen                 (param_olen),
    .res_wreq                   (res_wreq),
    .res_data                   (res_data),
    .wmst_ctrl_fixed_location   (wmst_ctrl_fixed_location),
    .wmst_ctrl_write_base       (wmst_ctrl_write_base),
    .wmst_ctrl_write_length     (wmst_ctrl_write_length),
    .wmst_ctrl_go               (wmst_ctrl_go),
    .wmst_ctrl_done             (wmst_ctrl_done),
    .wmst_user_write_buffer     (wmst_user_write_buffer),
    .wmst_user_write_input_data (wmst_user_write_input_data),
    .wmst_user_buffer_full      (wmst_user_buffer_full),
    .flag_over                  (flag_over),
    .busy                       (busy),
    .err_drop                   (err_drop)
  );

  // Monitor: every push to the write master is matched against the scoreboard
  always @(negedge clk) begin
    if (rst && wmst_user_write_buffer) begin
      logic [127:0] e;
      n_push++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL push_unexpected: got=%h required=none", wmst_user_write_input_data);
      end else begin
        e = exp_q.pop_front();
        if (wmst_user_write_input_data !== e) begin
          errors++;
          $display("FAIL push_data: got=%h required=%h", wmst_user_write_input_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got=%0h required=%0h", name, got, req);
    end
  endtask

  function automatic logic [127:0] mk(input int j);
    logic [31:0] b;
    b = 32'hA500_0000 + 32'(j) * 32'h10;
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [31:0] addr, input logic [9:0] len);
    param_ena   = 1'b1;
    param_oaddr = addr;
    param_olen  = len;
    cyc();
    param_ena   = 1'b0;
  endtask

  task automatic send_word(input logic [127:0] d, input bit acc, input logic [127:0] e);
    res_wreq = 1'b1;
    res_data = d;
    if (acc) exp_q.push_back(e);
    cyc();
    res_wreq = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      cyc();
      n++;
    end
    chk(name, 128'(exp_q.size()), 128'd0);
  endtask

  task automatic finish_job(input string name);
    wmst_ctrl_done = 1'b1;
    cyc();
    wmst_ctrl_done = 1'b0;
    chk({name, "_flag"}, 128'(flag_over), 128'd1);
    chk({name, "_busy"}, 128'(busy), 128'd0);
    cyc();
    chk({name, "_flag_pulse"}, 128'(flag_over), 128'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; param_ena = 1'b0; param_oaddr = '0; param_olen = '0;
    res_wreq = 1'b0; res_data = '0; wmst_ctrl_done = 1'b0; wmst_user_buffer_full = 1'b0;
    repeat (3) cyc();
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_go", 128'(wmst_ctrl_go), 128'd0);
    chk("rst_flag", 128'(flag_over), 128'd0);
    chk("rst_err", 128'(err_drop), 128'd0);
    chk("rst_wbuf", 128'(wmst_user_write_buffer), 128'd0);
    chk("rst_base", 128'(wmst_ctrl_write_base), 128'd0);
    chk("rst_len", 128'(wmst_ctrl_write_length), 128'd0);
    chk("rst_data", wmst_user_write_input_data, 128'd0);
    chk("rst_fixed", 128'(wmst_ctrl_fixed_location), 128'd0);
    rst = 1'b1;
    cyc();

    // Single job: olen=8 -> 2 words, 32 bytes
    start_job(32'h1000, 10'd8);
    chk("t1_go", 128'(wmst_ctrl_go), 128'd1);
    chk("t1_base", 128'(wmst_ctrl_write_base), 128'h1000);
    chk("t1_len", 128'(wmst_ctrl_write_length), 128'd32);
    chk("t1_busy", 128'(busy), 128'd1);
    send_word(mk(0), 1'b1, mk(0));
    chk("t1_latency", 128'(wmst_user_write_buffer), 128'd1);
    chk("t1_go_pulse", 128'(wmst_ctrl_go), 128'd0);
    send_word(mk(1), 1'b1, mk(1));
    drain("t1_drain");
    chk("t1_wait_busy", 128'(busy), 128'd1);
    finish_job("t1");

    // Tail mask: olen=6 -> second word keeps lanes 0,1 only
    start_job(32'h1800, 10'd6);
    chk("t2_len", 128'(wmst_ctrl_write_length), 128'd32);
    send_word({4{32'hFFFF_FFFF}}, 1'b1, {4{32'hFFFF_FFFF}});
    send_word({4{32'hFFFF_FFFF}}, 1'b1, 128'h00000000_00000000_FFFFFFFF_FFFFFFFF);
    drain("t2_drain");
    finish_job("t2");

    // Backpressure: 16 words fill the FIFO exactly while buffer_full is held
    wmst_user_buffer_full = 1'b1;
    n_push = 0;
    start_job(32'h8000, 10'd64);
    chk("t3_len", 128'(wmst_ctrl_write_length), 128'd256);
    for (int j = 0; j < 16; j++) send_word(mk(10 + j), 1'b1, mk(10 + j));
    repeat (3) cyc();
    chk("t3_no_push", 128'(n_push), 128'd0);
    chk("t3_no_drop", 128'(err_drop), 128'd0);
    wmst_user_buffer_full = 1'b0;
    repeat (16) cyc();
    chk("t3_consecutive", 128'(n_push), 128'd16);
    chk("t3_drained", 128'(exp_q.size()), 128'd0);
    send_word(mk(99), 1'b0, '0);
    chk("t3_extra_drop", 128'(err_drop), 128'd1);
    finish_job("t3");

    // Overflow: nwords=20, 17th strobe with FIFO full and no pop is dropped
    wmst_user_buffer_full = 1'b1;
    start_job(32'h9000, 10'd80);
    chk("t4_err_clear", 128'(err_drop), 128'd0);
    for (int j = 0; j < 16; j++) send_word(mk(40 + j), 1'b1, mk(40 + j));
    chk("t4_full_no_err", 128'(err_drop), 128'd0);
    send_word(mk(56), 1'b0, '0);
    chk("t4_overflow", 128'(err_drop), 128'd1);
    wmst_user_buffer_full = 1'b0;
    drain("t4_drain_a");
    for (int j = 0; j < 4; j++) send_word(mk(60 + j), 1'b1, mk(60 + j));
    drain("t4_drain_b");
    finish_job("t4");
    chk("t4_err_sticky", 128'(err_drop), 128'd1);

    // Ignored param_ena in STREAM and early done honoured after final push
    wmst_user_buffer_full = 1'b1;
    start_job(32'h2000, 10'd12);
    chk("t5_err_cleared", 128'(err_drop), 128'd0);
    for (int j = 0; j < 3; j++) send_word(mk(70 + j), 1'b1, mk(70 + j));
    start_job(32'h3000, 10'd4);
    chk("t5_base_hold", 128'(wmst_ctrl_write_base), 128'h2000);
    chk("t5_len_hold", 128'(wmst_ctrl_write_length), 128'd48);
    chk("t5_no_go", 128'(wmst_ctrl_go), 128'd0);
    wmst_ctrl_done = 1'b1;
    cyc();
    wmst_ctrl_done = 1'b0;
    chk("t5_early_no_flag", 128'(flag_over), 128'd0);
    chk("t5_early_busy", 128'(busy), 128'd1);
    wmst_user_buffer_full = 1'b0;
    drain("t5_drain");
    chk("t5_flag_not_yet", 128'(flag_over), 128'd0);
    cyc();
    chk("t5_flag", 128'(flag_over), 128'd1);
    chk("t5_idle", 128'(busy), 128'd0);
    cyc();

    // olen=0: immediate flag_over, no transfer
    start_job(32'h7000, 10'd0);
    chk("t6_flag", 128'(flag_over), 128'd1);
    chk("t6_no_go", 128'(wmst_ctrl_go), 128'd0);
    chk("t6_idle", 128'(busy), 128'd0);
    cyc();
    chk("t6_flag_pulse", 128'(flag_over), 128'd0);

    // Reset mid-STREAM with 3 words queued
    wmst_user_buffer_full = 1'b1;
    start_job(32'h4000, 10'd16);
    for (int j = 0; j < 3; j++) send_word(mk(80 + j), 1'b1, mk(80 + j));
    rst = 1'b0;
    cyc();
    chk("t7_busy", 128'(busy), 128'd0);
    chk("t7_base", 128'(wmst_ctrl_write_base), 128'd0);
    chk("t7_len", 128'(wmst_ctrl_write_length), 128'd0);
    chk("t7_data", wmst_user_write_input_data, 128'd0);
    chk("t7_flag", 128'(flag_over), 128'd0);
    rst = 1'b1;
    exp_q.delete();
    wmst_user_buffer_full = 1'b0;
    repeat (3) cyc();
    chk("t7_no_flag_after", 128'(flag_over), 128'd0);
    chk("t7_no_stale_push", 128'(wmst_user_write_buffer), 128'd0);
    n_push = 0;
    start_job(32'h5000, 10'd4);
    chk("t7_base_new", 128'(wmst_ctrl_write_base), 128'h5000);
    chk("t7_len_new", 128'(wmst_ctrl_write_length), 128'd16);
    send_word(mk(90), 1'b1, mk(90));
    drain("t7_drain");
    chk("t7_push_count", 128'(n_push), 128'd1);
    finish_job("t7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mv_wback.md
Name: mv_wback

Overview:
- Result write-back stage directly downstream of the matrix-vector FMA lanes.
- Each FMA result strobe delivers VW packed LDW-bit results. The block buffers these words in a show-ahead FIFO and zero-masks unused lanes of the final word.
- It sequences one write-master transfer per job: base/length, go, data stream under buffer_full backpressure, wait for done.
- It then pulses flag_over back to the config block.

Parameters:
- CW, 10, width of output-row count param_olen
- VW, 4, FMA lanes packed per result word
- LDW, 32, bits per lane result
- XAW, 32, write-master address width
- XDW, 128, write-master data width; must equal VW*LDW
- FAW, 4, FIFO address width; depth = 2^FAW words

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- param_ena  in  1  job start strobe
- param_oaddr  in  XAW  output byte base address
- param_olen  in  CW  number of output results (lanes)
- res_wreq  in  1  result word valid, one-cycle strobe
- res_data  in  XDW  packed lane results; lane g at [(g+1)*LDW-1:g*LDW]
- wmst_ctrl_fixed_location  out  1  constant 0
- wmst_ctrl_write_base  out  XAW  transfer byte base
- wmst_ctrl_write_length  out  XAW  transfer byte length
- wmst_ctrl_go  out  1  one-cycle transfer start
- wmst_ctrl_done  in  1  transfer complete
- wmst_user_write_buffer  out  1  data push to write master
- wmst_user_write_input_data  out  XDW  data word
- wmst_user_buffer_full  in  1  write master cannot accept
- flag_over  out  1  one-cycle job-complete pulse
- busy  out  1  high while state != IDLE
- err_drop  out  1  sticky: a result word was dropped

Behaviour:
- Reset (rst==0 at a clk edge): all outputs 0; state IDLE; FIFO empty; counters 0. Reset mid-job aborts the job with no flag_over.
- Word count: nwords = ceil(olen/VW); tail = olen mod VW.
- Byte length: wmst_ctrl_write_length = nwords*(XDW/8), zero-extended to XAW.
- States: IDLE, GO, STREAM, WAIT_DONE.
- IDLE:
  - param_ena at cycle t with olen!=0: at t+1, latch base/length, clear err_drop, pulse wmst_ctrl_go, and enter GO.
  - param_ena with olen==0: flag_over pulses at t+1; state stays IDLE.
- GO: lasts one cycle, then STREAM.
- STREAM:
  - wmst_user_write_buffer = fifo_not_empty & !wmst_user_buffer_full, combinational from registered FIFO state.
  - Data = FIFO head (show-ahead).
  - Each push increments sent_cnt. The push with sent_cnt==nwords-1 moves to WAIT_DONE.
- WAIT_DONE: on wmst_ctrl_done, pulse flag_over the next cycle and go to IDLE. A done seen earlier in GO/STREAM is also latched and honoured.
- param_ena while busy is ignored.
- FIFO write acceptance:
  - res_wreq is accepted in GO/STREAM/WAIT_DONE only while recv_cnt < nwords.
  - It is also rejected when the FIFO is full, unless a pop occurs in the same cycle.
  - Any rejected res_wreq sets err_drop; the data is discarded.
  - res_wreq in IDLE is dropped and sets err_drop.
- Latency: res_wreq at t with the FIFO empty and no backpressure gives wmst_user_write_buffer at t+1.
- Tail masking: on the word with recv_cnt==nwords-1 and tail!=0, lanes g>=tail are written to the FIFO as 0.
- Simultaneous push and pop on a full FIFO: both occur; count is unchanged.
- wmst_ctrl_write_base and wmst_ctrl_write_length hold their values until the next job.

Test Plan:
- Single job: olen=8, oaddr=0x1000, two res_wreq strobes, buffer_full=0 → go pulse 1 cycle after param_ena; base=0x1000, length=32; 2 pushes matching data; done → flag_over 1 cycle later, busy falls.
- Tail mask: olen=6, two words of all-0xFFFFFFFF lanes → second pushed word = 0x00000000_00000000_FFFFFFFF_FFFFFFFF; length=32.
- Backpressure:
  - olen=64 (16 words), buffer_full held high for 20 cycles while 16 strobes arrive → no push, no drop, FIFO full exactly.
  - Release → 16 consecutive pushes in order.
  - Then a 17th strobe → err_drop=1.
- Overflow: depth 16, buffer_full=1, 17 strobes with nwords=20 → 17th dropped, err_drop=1. Next param_ena after job end clears err_drop.
- Boundaries:
  - olen=0 → no go, flag_over at t+1.
  - param_ena during STREAM ignored (base unchanged).
  - Early done in STREAM → flag_over after the final push.
- Reset mid-STREAM with 3 words queued → all outputs 0 next cycle, no flag_over; a subsequent job runs cleanly.
